vending_trade_unit: RTL and testbench
=====================================

// Module: vending_trade_unit
// PURPOSE
//  Transaction core of the vending machine: holds per-product price and stock,
//  the customer wallet and the machine cash box. Executes buy, price-change and
//  customer-charge commands selected by the top-level mode code. It sits between
//  the mode decoder and the display/log logic and flags rejected commands on isError.
// PARAMETERS
//  NUM_PRODUCTS   8   number of product slots, addressed by productCode
//  INIT_STOCK     10  stock of every slot after reset
//  W              4   width of money, price, count and stock values
// PORTS
//  mainClock             in   1  system clock; all state changes on rising edge
//  resetN                in   1  synchronous active-low reset
//  cmdValid              in   1  one-cycle command strobe; mode is sampled when high
//  mode                  in   3  000 buy, 100 change price, 111 charge customer; others ignored
//  productCode           in   3  product slot for buy / change price / read-back
//  productCount          in   4  units to buy
//  newPrice              in   4  new unit price for change price
//  chargeCustomerAmount  in   4  amount added to the customer wallet
//  customerMoney         out  4  registered customer wallet
//  machineMoney          out  4  registered machine cash box
//  isError               out  1  registered result of the last executed command (1 = rejected)
//  done                  out  1  one-cycle pulse, the cycle after an executed command
//  priceOut              out  4  combinational price of slot productCode
//  stockOut              out  4  combinational stock of slot productCode
// BEHAVIOUR
//  - Reset (resetN=0 at an edge): customerMoney=0, machineMoney=0, isError=0, done=0,
//    stock[i]=INIT_STOCK, price[i]=i+1 (slot 0 = 1 ... slot 7 = 8). Reset wins over cmdValid.
//  - Single-cycle latency: a command on edge N updates all registers at edge N; new values
//    are visible from that edge on. done=1 for exactly the cycle after edge N.
//  - cmdValid=0 or an unsupported mode: no state change, isError holds, done=0.
//  - Buy (000): cost = price[code]*productCount in 8-bit arithmetic (max 225).
//    Reject (isError=1, nothing changes) if productCount==0, productCount>stock[code],
//    cost>customerMoney, or machineMoney+cost>15.
//    Else stock[code]-=count, customerMoney-=cost, machineMoney+=cost, isError=0.
//  - Change price (100): newPrice==0 -> reject, price unchanged; else price[code]=newPrice,
//    isError=0. Stock and money are untouched.
//  - Charge customer (111): sum = customerMoney+chargeCustomerAmount in 5 bits; sum>15 ->
//    reject, wallet unchanged; else customerMoney=sum, isError=0. Amount 0 is accepted.
//  - No saturation or wrap-around on any register; out-of-range results are rejected.
//  - isError is driven only by this block; it reflects the last executed command.
//  - Commands take effect strictly in order; one command per cycle, no back-pressure.
// TESTING
//  - Reset: hold resetN=0 for 2 edges -> money 0/0, isError=0, priceOut=code+1, stockOut=10.
//  - Charge 9 then 7 -> wallet 9, isError=0; second charge rejected (16>15), wallet stays 9.
//  - Buy code 2 (price 3), count 2 with wallet 9 -> wallet 3, machine 6, stock 8, isError=0.
//  - Buy code 7 (price 8), count 1 with wallet 3 -> isError=1, all registers unchanged.
//  - Change price code 2 to 0 -> isError=1, priceOut stays 3; then to 5 -> priceOut 5.
//  - Buy count 11 on stock 10, and count 0 -> both isError=1; assert resetN mid-sequence
//    together with cmdValid -> reset values, done=0.

Source files
------------

// File: rtl/vending_trade_unit_if.sv
// Command and status bundle between the mode decoder / display logic and the
// vending transaction core.
interface vending_trade_unit_if #(
  parameter int unsigned W = 4
);
  logic         cmdValid;
  logic [2:0]   mode;
  logic [2:0]   productCode;
  logic [W-1:0] productCount;
  logic [W-1:0] newPrice;
  logic [W-1:0] chargeCustomerAmount;
  logic [W-1:0] customerMoney;
  logic [W-1:0] machineMoney;
  logic         isError;
  logic         done;
  logic [W-1:0] priceOut;
  logic [W-1:0] stockOut;

  modport master (
    output cmdValid, mode, productCode, productCount, newPrice, chargeCustomerAmount,
    input  customerMoney, machineMoney, isError, done, priceOut, stockOut
  );

  modport slave (
    input  cmdValid, mode, productCode, productCount, newPrice, chargeCustomerAmount,
    output customerMoney, machineMoney, isError, done, priceOut, stockOut
  );
endinterface

// File: rtl/vending_trade_unit.sv
// Vending machine transaction core: per-slot price/stock tables, customer
// wallet and machine cash box. Executes buy, change-price and charge-customer
// commands in a single cycle and flags rejected commands on isError.
module vending_trade_unit #(
  parameter int unsigned NUM_PRODUCTS = 8,
  parameter int unsigned INIT_STOCK   = 10,
  parameter int unsigned W            = 4
) (
  input  logic                 mainClock,
  input  logic                 resetN,
  vending_trade_unit_if.slave  bus
);

  localparam int unsigned W2 = 2 * W;
  localparam int unsigned MONEY_MAX = (1 << W) - 1;

  typedef enum logic [2:0] {
    MODE_BUY    = 3'b000,
    MODE_PRICE  = 3'b100,
    MODE_CHARGE = 3'b111
  } mode_e;

  logic [W-1:0] price_q [NUM_PRODUCTS];
  logic [W-1:0] price_d [NUM_PRODUCTS];
  logic [W-1:0] stock_q [NUM_PRODUCTS];
  logic [W-1:0] stock_d [NUM_PRODUCTS];
  logic [W-1:0] cust_q, cust_d;
  logic [W-1:0] mach_q, mach_d;
  logic         err_q, err_d;
  logic         done_q, done_d;

  logic [W-1:0] unit_price;
  logic [W-1:0] unit_stock;
  logic [W2-1:0] cost;
  logic [W2-1:0] cash_sum;
  logic [W:0]    wallet_sum;
  logic          buy_reject;

  // Operand lookup and the wide arithmetic used to detect out-of-range results
  always_comb begin
    unit_price = price_q[bus.productCode];
    unit_stock = stock_q[bus.productCode];
    cost       = W2'(unit_price) * W2'(bus.productCount);
    cash_sum   = W2'(mach_q) + cost;
    wallet_sum = (W+1)'(cust_q) + (W+1)'(bus.chargeCustomerAmount);
    buy_reject = (bus.productCount == '0)
              || (bus.productCount > unit_stock)
              || (cost > W2'(cust_q))
              || (cash_sum > W2'(MONEY_MAX));
  end

  // Next-state: decode the strobed command and either commit it or reject it
  always_comb begin
    price_d = price_q;
    stock_d = stock_q;
    cust_d  = cust_q;
    mach_d  = mach_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (bus.cmdValid) begin
      case (mode_e'(bus.mode))
        MODE_BUY: begin
          done_d = 1'b1;
          if (buy_reject) begin
            err_d = 1'b1;
          end else begin
            err_d                     = 1'b0;
            stock_d[bus.productCode]  = unit_stock - bus.productCount;
            cust_d                    = cust_q - cost[W-1:0];
            mach_d                    = cash_sum[W-1:0];
          end
        end
        MODE_PRICE: begin
          done_d = 1'b1;
          if (bus.newPrice == '0) begin
            err_d = 1'b1;
          end else begin
            err_d                    = 1'b0;
            price_d[bus.productCode] = bus.newPrice;
          end
        end
        MODE_CHARGE: begin
          done_d = 1'b1;
          if (wallet_sum[W]) begin
            err_d = 1'b1;
          end else begin
            err_d  = 1'b0;
            cust_d = wallet_sum[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; synchronous reset restores default prices and full stock
  always_ff @(posedge mainClock) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
        price_q[i] <= W'(i + 1);
        stock_q[i] <= W'(INIT_STOCK);
      end
      cust_q <= '0;
      mach_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      price_q <= price_d;
      stock_q <= stock_d;
      cust_q  <= cust_d;
      mach_q  <= mach_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Registered status plus combinational read-back of the addressed slot
  always_comb begin
    bus.customerMoney = cust_q;
    bus.machineMoney  = mach_q;
    bus.isError       = err_q;
    bus.done          = done_q;
    bus.priceOut      = price_q[bus.productCode];
    bus.stockOut      = stock_q[bus.productCode];
  end

endmodule

// File: tb/tb_vending_trade_unit.sv
// Self-checking bench for vending_trade_unit: directed scenarios pinned with
// literal expectations, then randomized commands checked every cycle against
// an arithmetic reference model of the wallet, cash box and slot tables.
module tb_vending_trade_unit;

  logic mainClock;
  logic resetN;

  vending_trade_unit_if #(.W(4)) bus ();

  vending_trade_unit #(
    .NUM_PRODUCTS(8),
    .INIT_STOCK  (10),
    .W           (4)
  ) dut (
    .mainClock(mainClock),
    .resetN   (resetN),
    .bus      (bus)
  );

  initial mainClock = 1'b0;
  always #5 mainClock = ~mainClock;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  int m_price [8];
  int m_stock [8];
  int m_cust, m_mach;
  bit m_err, m_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: applies the command rules with plain integer arithmetic
  always @(posedge mainClock) begin
    int c, cost;
    if (!resetN) begin
      for (int i = 0; i < 8; i++) begin
        m_price[i] = i + 1;
        m_stock[i] = 10;
      end
      m_cust = 0; m_mach = 0; m_err = 0; m_done = 0;
    end else begin
      m_done = 0;
      c = int'(bus.productCode);
      if (bus.cmdValid) begin
        case (bus.mode)
          3'b000: begin
            m_done = 1;
            cost = m_price[c] * int'(bus.productCount);
            if (bus.productCount == 0 || int'(bus.productCount) > m_stock[c] ||
                cost > m_cust || m_mach + cost > 15) begin
              m_err = 1;
            end else begin
              m_err = 0;
              m_stock[c] -= int'(bus.productCount);
              m_cust -= cost;
              m_mach += cost;
            end
          end
          3'b100: begin
            m_done = 1;
            if (bus.newPrice == 0) m_err = 1;
            else begin m_err = 0; m_price[c] = int'(bus.newPrice); end
          end
          3'b111: begin
            m_done = 1;
            if (m_cust + int'(bus.chargeCustomerAmount) > 15) m_err = 1;
            else begin m_err = 0; m_cust += int'(bus.chargeCustomerAmount); end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge mainClock) begin
    if (cmp_en) begin
      chk("customerMoney", int'(bus.customerMoney), m_cust);
      chk("machineMoney",  int'(bus.machineMoney),  m_mach);
      chk("isError",       int'(bus.isError),       int'(m_err));
      chk("done",          int'(bus.done),          int'(m_done));
      chk("priceOut",      int'(bus.priceOut),      m_price[bus.productCode]);
      chk("stockOut",      int'(bus.stockOut),      m_stock[bus.productCode]);
    end
  end

  task automatic drive(input bit v, input logic [2:0] md, input logic [2:0] code,
                       input logic [3:0] cnt, input logic [3:0] np, input logic [3:0] amt);
    bus.cmdValid             = v;
    bus.mode                 = md;
    bus.productCode          = code;
    bus.productCount         = cnt;
    bus.newPrice             = np;
    bus.chargeCustomerAmount = amt;
    @(posedge mainClock);
    #1;
  endtask

  initial begin
    resetN = 1'b0;
    bus.cmdValid = 1'b0; bus.mode = '0; bus.productCode = '0;
    bus.productCount = '0; bus.newPrice = '0; bus.chargeCustomerAmount = '0;

    // Reset held for two edges
    repeat (2) @(posedge mainClock);
    #1;
    cmp_en = 1'b1;
    chk("rst_cust", int'(bus.customerMoney), 0);
    chk("rst_mach", int'(bus.machineMoney), 0);
    chk("rst_err",  int'(bus.isError), 0);
    chk("rst_done", int'(bus.done), 0);
    for (int c = 0; c < 8; c++) begin
      bus.productCode = 3'(c);
      #1;
      chk("rst_price", int'(bus.priceOut), c + 1);
      chk("rst_stock", int'(bus.stockOut), 10);
    end
    resetN = 1'b1;

    // Charge 9 then 7 (second overflows to 16)
    drive(1, 3'b111, 0, 0, 0, 9);
    chk("chg9_wallet", int'(bus.customerMoney), 9);
    chk("chg9_err", int'(bus.isError), 0);
    chk("chg9_done", int'(bus.done), 1);
    drive(1, 3'b111, 0, 0, 0, 7);
    chk("chg7_wallet", int'(bus.customerMoney), 9);
    chk("chg7_err", int'(bus.isError), 1);

    // Buy two of slot 2 at price 3
    drive(1, 3'b000, 2, 2, 0, 0);
    chk("buy_wallet", int'(bus.customerMoney), 3);
    chk("buy_mach",   int'(bus.machineMoney), 6);
    chk("buy_stock",  int'(bus.stockOut), 8);
    chk("buy_err",    int'(bus.isError), 0);

    // Unaffordable buy of slot 7
    drive(1, 3'b000, 7, 1, 0, 0);
    chk("poor_err",    int'(bus.isError), 1);
    chk("poor_wallet", int'(bus.customerMoney), 3);
    chk("poor_mach",   int'(bus.machineMoney), 6);
    chk("poor_stock",  int'(bus.stockOut), 10);

    // Price change to 0 rejected, then to 5 accepted
    drive(1, 3'b100, 2, 0, 0, 0);
    chk("price0_err", int'(bus.isError), 1);
    chk("price0_val", int'(bus.priceOut), 3);
    drive(1, 3'b100, 2, 0, 5, 0);
    chk("price5_err", int'(bus.isError), 0);
    chk("price5_val", int'(bus.priceOut), 5);

    // Count beyond stock, then zero count
    drive(1, 3'b111, 0, 0, 0, 12);
    chk("chg12_wallet", int'(bus.customerMoney), 15);
    drive(1, 3'b000, 0, 11, 0, 0);
    chk("cnt11_err", int'(bus.isError), 1);
    chk("cnt11_stock", int'(bus.stockOut), 10);
    drive(1, 3'b000, 0, 0, 0, 0);
    chk("cnt0_err", int'(bus.isError), 1);

    // Idle and unsupported mode: no done, error held
    drive(0, 3'b111, 0, 0, 0, 1);
    chk("idle_done", int'(bus.done), 0);
    chk("idle_err",  int'(bus.isError), 1);
    drive(1, 3'b010, 0, 0, 0, 1);
    chk("badmode_done", int'(bus.done), 0);
    chk("badmode_wallet", int'(bus.customerMoney), 15);

    // Cash box limit: machine 6 + cost 10 > 15
    drive(1, 3'b000, 1, 5, 0, 0);
    chk("cashcap_err", int'(bus.isError), 1);
    chk("cashcap_mach", int'(bus.machineMoney), 6);

    // Reset together with a command
    resetN = 1'b0;
    drive(1, 3'b111, 2, 0, 0, 1);
    chk("midrst_wallet", int'(bus.customerMoney), 0);
    chk("midrst_mach",   int'(bus.machineMoney), 0);
    chk("midrst_done",   int'(bus.done), 0);
    chk("midrst_err",    int'(bus.isError), 0);
    chk("midrst_price",  int'(bus.priceOut), 3);
    resetN = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [2:0] md;
      logic [3:0] cnt, np;
      resetN = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      r = $urandom_range(0, 9);
      if (r < 4)      md = 3'b000;
      else if (r < 6) md = 3'b100;
      else if (r < 9) md = 3'b111;
      else begin
        md = 3'($urandom_range(1, 6));
        if (md == 3'b100) md = 3'b011;
      end
      cnt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      np  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      drive(($urandom_range(0, 7) != 0), md, 3'($urandom_range(0, 7)), cnt, np,
            4'($urandom_range(0, 15)));
    end
    resetN = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge mainClock);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
